// File: rtl/xtor_core_arbiter.sv
// Round-robin arbiter that time-shares one XtorCore increment datapath among NUM_REQ requesters.
// Latency: accept at T, core_valid at T+1, rsp_valid at T+3; one transaction in flight, 4 cycles minimum.
// Backpressure: no grant while busy or while core_ready=0; the response is held until rsp_ready.
// Optional feature: define XTOR_ARB_STATS_EN to add per-requester saturating grant counters (stat_grants).
module xtor_core_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  input  logic                      core_ready,
  output logic                      core_valid,
  output logic [DATA_W-1:0]         core_data_i,
  input  logic [DATA_W-1:0]         core_data_o
`ifdef XTOR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_grants
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] cand;
  logic [ID_W:0]   sum;
  logic            pick_found;
  logic            grant;
  logic            abort;

  // Round-robin search: first valid requester after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    sum        = '0;
    cand       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      cand = sum[ID_W-1:0];
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  // Grant only from IDLE with the core ready; reset masks the combinational accept.
  always_comb begin
    grant     = (state == S_IDLE) && core_ready && pick_found && !reset;
    abort     = ((state == S_ISSUE) || (state == S_CAPTURE)) && !core_ready;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (pick == ID_W'(i));
    end
  end

  // Next-state logic; losing core_ready mid-transaction jumps straight to an error response.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (grant) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = core_ready ? S_CAPTURE : S_RESP;
      S_CAPTURE: state_nxt = S_RESP;
      S_RESP:    if (rsp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: latch the granted request, drive the core for one cycle, capture and hold the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      gnt_id      <= '0;
      core_valid  <= 1'b0;
      core_data_i <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      core_valid <= grant;
      if (grant) begin
        core_data_i <= req_data[pick*DATA_W +: DATA_W];
        gnt_id      <= pick;
        rr_ptr      <= pick;
      end
      if ((state == S_CAPTURE) || abort) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt_id;
        rsp_err   <= abort;
        rsp_data  <= abort ? '0 : core_data_o;
      end else if ((state == S_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef XTOR_ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];

  // Per-requester grant counters, saturating; aborted grants still count.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant && (pick == ID_W'(i)) && (grant_cnt[i] != 16'hFFFF)) begin
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Flatten the counters onto the stats port.
  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grants[i*16 +: 16] = grant_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_xtor_core_arbiter.sv
// Directed bench for xtor_core_arbiter with a behavioural XtorCore (registered +1).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
// Each scenario task does its own comparisons and steps the shared counters.
`timescale 1ns/1ps
module tb_xtor_core_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      core_ready = 1'b1;
  logic                      core_valid;
  logic [DATA_W-1:0]         core_data_i;
  logic [DATA_W-1:0]         core_data_o;
`ifdef XTOR_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     stat_grants;
`endif

  int checks = 0;
  int passed = 0;

  xtor_core_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .core_ready  (core_ready),
    .core_valid  (core_valid),
    .core_data_i (core_data_i),
    .core_data_o (core_data_o)
`ifdef XTOR_ARB_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  always #5 clock = ~clock;

  // XtorCore stand-in: registered increment of data_i on valid.
  always @(posedge clock) begin
    if (reset) core_data_o <= '0;
    else if (core_valid) core_data_o <= core_data_i + 32'd1;
  end

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1; core_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; req_valid = 4'hF;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, core_valid, core_data_i} !== '0)
      $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b rsp_id=%0d rsp_data=%h rsp_err=%b core_valid=%b core_data_i=%h expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, core_valid, core_data_i);
    else passed++;
    req_valid = '0;
  endtask

  task automatic test_single();
    reset_dut();
    req_data[0*32 +: 32] = 32'h12345678; req_valid = 4'b0001; #1;
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL single_grant: req_ready=%b expected 0001", req_ready);
    else passed++;
    @(negedge clock); req_valid = '0; #1;
    checks++;
    if (core_valid !== 1'b1 || core_data_i !== 32'h12345678)
      $display("FAIL single_issue: core_valid=%b core_data_i=%h expected 1 12345678", core_valid, core_data_i);
    else passed++;
    @(negedge clock); #1;
    checks++;
    if (core_valid !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL single_capture: core_valid=%b rsp_valid=%b expected 0 0", core_valid, rsp_valid);
    else passed++;
    @(negedge clock); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h12345679 || rsp_err !== 1'b0)
      $display("FAIL single_resp: rsp_valid=%b rsp_id=%0d rsp_data=%h rsp_err=%b expected 1 0 12345679 0",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    else passed++;
    @(negedge clock); #1;
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL single_drop: rsp_valid=%b expected 0", rsp_valid);
    else passed++;
  endtask

  task automatic test_rr_order();
    reset_dut();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*32 +: 32] = 32'hA000_0000 + i;
    req_valid = 4'hF; #1;
    for (int k = 0; k < 6; k++) begin
      int exp_id;
      int waited;
      logic busy_bad;
      exp_id = k % 4;
      waited = 0;
      while (req_ready === '0 && waited < 8) begin
        @(negedge clock); #1; waited++;
      end
      checks++;
      if (req_ready !== (4'b0001 << exp_id))
        $display("FAIL rr_grant_%0d: req_ready=%b expected requester %0d", k, req_ready, exp_id);
      else passed++;
      busy_bad = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clock); #1;
        if (req_ready !== '0) busy_bad = 1'b1;
      end
      checks++;
      if (busy_bad) $display("FAIL rr_busy_%0d: req_ready seen while busy, expected none", k);
      else passed++;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(exp_id) || rsp_data !== 32'hA000_0000 + exp_id + 1)
        $display("FAIL rr_resp_%0d: rsp_valid=%b rsp_id=%0d rsp_data=%h expected 1 %0d %h",
                 k, rsp_valid, rsp_id, rsp_data, exp_id, 32'hA000_0000 + exp_id + 1);
      else passed++;
      @(negedge clock); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic busy_bad;
    reset_dut();
    rsp_ready = 1'b0; req_data[2*32 +: 32] = 32'h10; req_valid = 4'b0100; #1;
    checks++;
    if (req_ready !== 4'b0100) $display("FAIL bp_grant: req_ready=%b expected 0100", req_ready);
    else passed++;
    @(negedge clock); req_valid = 4'b0001; #1;
    busy_bad = (req_ready !== '0);
    @(negedge clock); #1;
    if (req_ready !== '0) busy_bad = 1'b1;
    checks++;
    if (busy_bad) $display("FAIL bp_busy: req_ready seen while busy, expected none");
    else passed++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h11 || req_ready !== '0)
        $display("FAIL bp_hold_%0d: rsp_valid=%b rsp_id=%0d rsp_data=%h req_ready=%b expected 1 2 00000011 0000",
                 c, rsp_valid, rsp_id, rsp_data, req_ready);
      else passed++;
    end
    @(negedge clock); rsp_ready = 1'b1; #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h11 || req_ready !== '0)
      $display("FAIL bp_handshake: rsp_valid=%b rsp_data=%h req_ready=%b expected 1 00000011 0000",
               rsp_valid, rsp_data, req_ready);
    else passed++;
    @(negedge clock); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001)
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b expected 0 0001", rsp_valid, req_ready);
    else passed++;
    req_valid = '0;
  endtask

  task automatic test_wrap();
    reset_dut();
    req_data[1*32 +: 32] = 32'hFFFF_FFFF; req_valid = 4'b0010; #1;
    checks++;
    if (req_ready !== 4'b0010) $display("FAIL wrap_grant: req_ready=%b expected 0010", req_ready);
    else passed++;
    @(negedge clock); req_valid = '0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL wrap_resp: rsp_valid=%b rsp_id=%0d rsp_data=%h rsp_err=%b expected 1 1 00000000 0",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    else passed++;
  endtask

  task automatic test_core_ready_loss();
    logic bad;
    reset_dut();
    core_ready = 1'b0; req_data[0*32 +: 32] = 32'h55; req_valid = 4'b0001;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (req_ready !== '0) bad = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (bad) $display("FAIL nocore_grant: req_ready seen with core_ready=0, expected none");
    else passed++;
    core_ready = 1'b1; #1;
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL loss_grant: req_ready=%b expected 0001", req_ready);
    else passed++;
    @(negedge clock); req_valid = '0; #1;
    @(negedge clock); core_ready = 1'b0; #1;
    @(negedge clock); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_id !== 2'd0)
      $display("FAIL loss_capture_resp: rsp_valid=%b rsp_err=%b rsp_data=%h rsp_id=%0d expected 1 1 00000000 0",
               rsp_valid, rsp_err, rsp_data, rsp_id);
    else passed++;
    @(negedge clock); core_ready = 1'b1; req_valid = 4'b0011; #1;
    checks++;
    if (req_ready !== 4'b0010) $display("FAIL loss_rr_advance: req_ready=%b expected 0010", req_ready);
    else passed++;
    @(negedge clock); req_valid = '0; core_ready = 1'b0; #1;
    @(negedge clock); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_id !== 2'd1)
      $display("FAIL loss_issue_resp: rsp_valid=%b rsp_err=%b rsp_data=%h rsp_id=%0d expected 1 1 00000000 1",
               rsp_valid, rsp_err, rsp_data, rsp_id);
    else passed++;
    core_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    reset_dut();
    req_data[0*32 +: 32] = 32'h77; req_valid = 4'b0001; #1;
    @(negedge clock); req_valid = '0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, core_valid, core_data_i} !== '0)
      $display("FAIL midreset_outputs: rsp_valid=%b rsp_data=%h core_valid=%b core_data_i=%h expected all 0",
               rsp_valid, rsp_data, core_valid, core_data_i);
    else passed++;
`ifdef XTOR_ARB_STATS_EN
    checks++;
    if (stat_grants !== '0) $display("FAIL stats_reset: stat_grants=%h expected 0", stat_grants);
    else passed++;
`endif
    reset = 1'b0; req_valid = 4'b0011; #1;
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL midreset_priority: req_ready=%b expected 0001", req_ready);
    else passed++;
    @(negedge clock); req_valid = '0; #1;
`ifdef XTOR_ARB_STATS_EN
    checks++;
    if (stat_grants !== 64'h0000_0000_0000_0001)
      $display("FAIL stats_count: stat_grants=%h expected 0000000000000001", stat_grants);
    else passed++;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_backpressure();
    test_wrap();
    test_core_ready_loss();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
